// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter
//   Turns the read port of a synchronous FIFO into a valid/ready stream with
//   full throughput. The FIFO returns data one cycle after an accepted read,
//   so a 2-entry prefetch/skid buffer absorbs the read latency. The adapter
//   also adds packet framing: m_last marks every PKT_LEN-th beat.
//
// Ports
//   clk           rising-edge clock, shared with the FIFO
//   rst_n         asynchronous active-low reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid the cycle after an issued read
//   fifo_rd_en    read request to the FIFO (combinational)
//   m_valid       stream beat available
//   m_ready       consumer accepts the beat when m_valid & m_ready
//   m_data        beat data (head of buffer)
//   m_last        beat is the final beat of a packet
//   level         beats held in buffer (0..2)
module fifo_stream_adapter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [1:0]       level
);

  localparam int unsigned CntW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PKT_LEN - 1);

  logic [WIDTH-1:0] buf_q [2];
  logic             head_q, tail_q;
  logic [1:0]       level_q;
  logic             inflight_q;
  logic [CntW-1:0]  beat_cnt_q;

  logic       pop;
  logic [2:0] occ_after;

  assign m_valid = (level_q != 2'd0);
  assign m_data  = buf_q[head_q];
  assign m_last  = m_valid && (beat_cnt_q == LastCnt);
  assign level   = level_q;
  assign pop     = m_valid & m_ready;

  // Occupancy once this cycle's in-flight beat lands and any pop leaves.
  // A pop implies level_q >= 1, so the subtraction never underflows.
  assign occ_after  = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = rst_n & ~fifo_empty & (occ_after < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      level_q    <= 2'd0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      // The invariant level + inflight <= 2 keeps occ_after inside 0..2.
      level_q    <= occ_after[1:0];
      if (inflight_q) begin
        buf_q[tail_q] <= fifo_rd_data;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q     <= ~head_q;
        beat_cnt_q <= (beat_cnt_q == LastCnt) ? '0 : beat_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb_fifo_stream_adapter
//   Drives fifo_stream_adapter from a behavioural sync-FIFO model and checks
//   the stream against an order/framing scoreboard every cycle, plus directed
//   literal expectations for latency, throughput, stall, gap and reset.
module tb_fifo_stream_adapter;

  localparam int W  = 8;
  localparam int PL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m_ready = 1'b0;
  logic         flush = 1'b0;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_rd_data = '0;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  logic [1:0]   level;

  fifo_stream_adapter #(.WIDTH(W), .PKT_LEN(PL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .level        (level)
  );

  always #5 clk = ~clk;

  // Sync FIFO model: registered read data, flushed alongside the adapter.
  logic [W-1:0] fifo_mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= fifo_mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Scoreboard: expected beat order and accepted-beat history since reset.
  logic [W-1:0] exp_q [$];
  logic [W-1:0] pop_data_q [$];
  logic         pop_last_q [$];
  int           pop_cnt = 0;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic clear_model();
    exp_q.delete();
    pop_data_q.delete();
    pop_last_q.delete();
    pop_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    flush = 1'b1;
    clear_model();
    @(posedge clk);
    #1 flush = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [3:0] last_vec4();
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < 4 && i < pop_last_q.size(); i++) v[i] = pop_last_q[i];
    return v;
  endfunction

  // Per-cycle compare against the scoreboard.
  logic         hold_p = 1'b0;
  logic [W-1:0] data_p;
  logic         last_p;
  logic [W-1:0] exp_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_rd_en", fifo_rd_en, 0);
      check("reset_valid", m_valid, 0);
      hold_p = 1'b0;
    end else begin
      check("rd_en_when_empty", fifo_rd_en & fifo_empty, 0);
      check("level_le_2", (level <= 2'd2), 1);
      check("valid_vs_level", m_valid, (level != 2'd0));
      if (hold_p) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_stable", m_data, data_p);
        check("stall_last_stable", m_last, last_p);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", m_valid, 0);
        end else begin
          exp_d = exp_q.pop_front();
          check("beat_data", m_data, exp_d);
          check("beat_last", m_last, ((pop_cnt % PL) == PL - 1));
          pop_data_q.push_back(m_data);
          pop_last_q.push_back(m_last);
          pop_cnt++;
        end
      end
      hold_p = m_valid & ~m_ready;
      data_p = m_data;
      last_p = m_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int rd_cnt;
    int n_pop;
    int first_c;
    int last_c;
    int base;
    int sent;

    // 1: FIFO preloaded during reset, consumer ready.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_rd_en_in_reset", fifo_rd_en, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t1_first_rd_en", fifo_rd_en, 1);
    check("t1_valid_c0", m_valid, 0);
    @(negedge clk);
    check("t1_valid_c1", m_valid, 0);
    @(negedge clk);
    check("t1_valid_c2", m_valid, 1);
    check("t1_data0", m_data, 8'h11);
    @(negedge clk);
    check("t1_data1", m_data, 8'h22);
    @(negedge clk);
    check("t1_data2", m_data, 8'h33);
    @(negedge clk);
    check("t1_drained", m_valid, 0);

    // 2: 8 beats back-to-back, framing on beats 4 and 8.
    do_reset();
    @(posedge clk);
    #1 for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    rd_cnt = 0; n_pop = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
      if (m_valid && m_ready) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        n_pop++;
      end
    end
    check("t2_rd_en_count", rd_cnt, 8);
    check("t2_beats", n_pop, 8);
    check("t2_no_bubbles", last_c - first_c, 7);
    check("t2_last_lo", last_vec4(), 4'b1000);
    check("t2_last_beat8", (pop_last_q.size() == 8) && pop_last_q[7], 1);

    // 3: consumer stalls for 10 cycles with 5 beats queued.
    @(posedge clk);
    #1 m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check("t3_level_full", level, 2);
        check("t3_rd_en_off", fifo_rd_en, 0);
        check("t3_data_const", m_data, 8'hA0);
      end
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    drain("t3_drain", 50);
    check("t3_count", pop_data_q.size(), 13);
    check("t3_first_after_stall", (pop_data_q.size() == 13) ? pop_data_q[8] : 8'h00, 8'hA0);
    check("t3_last_after_stall", (pop_data_q.size() == 13) ? pop_data_q[12] : 8'h00, 8'hA4);

    // 4: 200 random beats with random backpressure.
    base = pop_cnt;
    sent = 0;
    for (int c = 0; c < 3000 && sent < 200; c++) begin
      @(posedge clk);
      #1 m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7) begin
        push(8'($urandom));
        sent++;
      end
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    drain("t4_drain", 100);
    check("t4_beats", pop_cnt - base, 200);

    // 5: FIFO runs dry mid-packet, framing resumes after the gap.
    do_reset();
    @(posedge clk);
    #1 push(8'h51);
    push(8'h52);
    drain("t5_drain_a", 20);
    repeat (4) begin
      @(negedge clk);
      check("t5_gap_valid", m_valid, 0);
    end
    @(posedge clk);
    #1 push(8'h53);
    push(8'h54);
    drain("t5_drain_b", 20);
    check("t5_last_pattern", last_vec4(), 4'b1000);

    // 6: reset while streaming with a beat buffered and one in flight.
    @(posedge clk);
    #1 for (int i = 0; i < 10; i++) push(8'h60 + 8'(i));
    for (int c = 0; c < 30 && pop_data_q.size() < 6; c++) @(negedge clk);
    @(posedge clk);
    #3 check("t6_busy_valid", m_valid, 1);
    check("t6_busy_inflight", dut.inflight_q, 1);
    rst_n = 1'b0;
    flush = 1'b1;
    clear_model();
    #1 check("t6_async_valid", m_valid, 0);
    check("t6_async_data", m_data, 0);
    check("t6_async_last", m_last, 0);
    check("t6_async_level", level, 0);
    check("t6_async_rd_en", fifo_rd_en, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 for (int i = 0; i < 4; i++) push(8'h71 + 8'(i));
    drain("t6_drain", 20);
    check("t6_first_data", (pop_data_q.size() > 0) ? pop_data_q[0] : 8'h00, 8'h71);
    check("t6_last_pattern", last_vec4(), 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
